seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial bit-pattern detector generalising the fixed non-overlapping 1010 Mealy/Moore detectors. A single instance detects any PAT_W-bit pattern in a serial stream gated by a valid qualifier, with overlap selectable by parameter. It produces both a Mealy (same-cycle) and a Moore (registered) match output, plus an optional saturating match counter. It sits on the serial input path in the same place as the earlier detectors.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits, 2..16
- PATTERN, 4'b1010, pattern to match; MSB is the oldest bit received
- OVERLAP, 0, 0 = non-overlapping detection, 1 = overlapping detection
- CNT_W, 8, match counter width, 1..32

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din is consumed on a rising edge only when high
- cnt_clr  input  1  synchronous clear of match_cnt and cnt_ovf
- dout_mealy  output  1  combinational match: the current valid din completes the pattern
- dout_moore  output  1  registered match, high for one cycle after the completing edge
- match_cnt  output  CNT_W  number of matches, saturating
- cnt_ovf  output  1  sticky flag: a match occurred while match_cnt was saturated

## Operation
- State: history register hist[PAT_W-1:0] holding the most recent bits, with hist[0] the newest. Fill counter fill (width clog2(PAT_W+1)) counts valid bits since reset or since the last match in non-overlap mode. fill saturates at PAT_W.
- Candidate window: win = {hist[PAT_W-2:0], din}.
- Match condition: hit = din_valid && (fill >= PAT_W-1) && (win == PATTERN).
- On each rising edge with din_valid = 1:
  - hist <= win.
  - If hit and OVERLAP = 0, fill <= 0. Otherwise fill <= min(fill+1, PAT_W).
- With din_valid = 0: hist and fill hold, and hit = 0.
- dout_mealy = hit. It is purely combinational from din, din_valid, hist and fill.
- dout_moore <= hit on every edge. It is therefore high for exactly one cycle per match and drops to 0 on the first edge where hit = 0.
- match_cnt update on each edge:
  - cnt_clr = 1 takes priority and clears the counter first. match_cnt <= hit ? 1 : 0, and cnt_ovf <= 0.
  - Otherwise, if hit and match_cnt < 2^CNT_W-1, match_cnt increments.
  - Otherwise, if hit and match_cnt is saturated, match_cnt holds and cnt_ovf <= 1.
- Bits before the first PAT_W valid bits never match, because fill gates the compare. Stale hist contents are therefore irrelevant after reset.

## Timing
- Reset (rst = 0) asynchronously forces: hist = 0, fill = 0, dout_moore = 0, match_cnt = 0, cnt_ovf = 0. dout_mealy is 0 while in reset.
- Reset asserted mid-pattern discards all partial progress. Detection restarts from an empty history on release.
- Mealy latency: 0 cycles. dout_mealy is high in the same cycle the completing bit is presented.
- Moore latency: 1 cycle. dout_moore is high in the cycle after the completing edge.
- match_cnt reflects a match one cycle after the completing edge, aligned with dout_moore.
- Back-to-back matches:
  - OVERLAP = 1: a completing bit can immediately follow a match, so a 1-bit-apart match is possible (e.g. pattern 1111).
  - OVERLAP = 0: the next match needs at least PAT_W further valid bits.
- din_valid gaps do not break a sequence. Bits separated by invalid cycles are treated as contiguous.

## Configuration
- SEQDET_MATCH_CNT_EN defined: the match_cnt and cnt_ovf logic and cnt_clr handling are compiled in, as described above.
- Not defined: the counter logic is removed. match_cnt is tied to 0, cnt_ovf is tied to 0, and cnt_clr is ignored. Detection outputs are unaffected.

## Test plan
- Default parameters (PATTERN = 1010, OVERLAP = 0), valid bits 1,1,0,1,0,1,0:
  - dout_mealy is high only on the 5th bit.
  - dout_moore is high only in the cycle after the 5th bit.
  - match_cnt ends at 1.
- Same stream with OVERLAP = 1:
  - Matches occur on the 5th and 7th bits.
  - match_cnt ends at 2.
- Valid bits 1,0 then din_valid = 0 for 3 cycles, then bits 1,0:
  - Exactly one match, on the last bit.
  - No output pulses during the gap.
- Reset mid-pattern: bits 1,0,1, then rst = 0 for one cycle, then bits 0,1,0,1,0:
  - No match on the first 0 after reset.
  - A match occurs on the final 0.
  - All outputs are 0 during reset.
- CNT_W = 2 with the macro defined, 4 separated matches:
  - match_cnt = 3 and cnt_ovf = 1 after the 4th match.
  - Asserting cnt_clr in the same cycle as a 5th hit gives match_cnt = 1 and cnt_ovf = 0.
- PAT_W = 3, PATTERN = 3'b111, OVERLAP = 1, five consecutive 1s:
  - Matches occur on bits 3, 4 and 5.
  - With OVERLAP = 0, a match occurs only on bit 3.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with Mealy and Moore match outputs.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int               OVERLAP = 0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cnt_clr,
    output logic             dout_mealy,
    output logic             dout_moore,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_ovf
);
    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  hist_q, hist_d, win;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              moore_q, moore_d;
    logic              hit;

    // fill gates the compare, so stale history never produces a match
    always_comb begin
        win    = {hist_q[PAT_W-2:0], din};
        hit    = din_valid && (fill_q >= FILL_ARM) && (win == PATTERN);
        hist_d = hist_q;
        fill_d = fill_q;
        if (din_valid) begin
            hist_d = win;
            if (hit && OVERLAP == 0)
                fill_d = '0;
            else if (fill_q != FILL_MAX)
                fill_d = fill_q + 1'b1;
        end
        moore_d = hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            moore_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            moore_q <= moore_d;
        end
    end

    assign dout_mealy = hit;
    assign dout_moore = moore_q;

`ifdef SEQDET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // clear wins, but a hit in the clearing cycle still counts as one
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (cnt_clr) begin
            cnt_d = hit ? CNT_W'(1) : '0;
            ovf_d = 1'b0;
        end else if (hit) begin
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
            else
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign match_cnt = cnt_q;
    assign cnt_ovf   = ovf_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
    assign cnt_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: five instances share one stimulus stream.
// Hit vectors are ordered {e,d,c,b,a}.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic cnt_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // a: 1010 no-overlap, b: 1010 overlap, c: 1010 CNT_W=2, d: 111 overlap, e: 111 no-overlap
    logic       m_a, m_b, m_c, m_d, m_e;
    logic       q_a, q_b, q_c, q_d, q_e;
    logic [7:0] cnt_a, cnt_b, cnt_d, cnt_e;
    logic [1:0] cnt_c;
    logic       ovf_a, ovf_b, ovf_c, ovf_d, ovf_e;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout_mealy(m_a), .dout_moore(q_a), .match_cnt(cnt_a), .cnt_ovf(ovf_a));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout_mealy(m_b), .dout_moore(q_b), .match_cnt(cnt_b), .cnt_ovf(ovf_b));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout_mealy(m_c), .dout_moore(q_c), .match_cnt(cnt_c), .cnt_ovf(ovf_c));
    seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(8)) u_d (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout_mealy(m_d), .dout_moore(q_d), .match_cnt(cnt_d), .cnt_ovf(ovf_d));
    seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(0), .CNT_W(8)) u_e (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .dout_mealy(m_e), .dout_moore(q_e), .match_cnt(cnt_e), .cnt_ovf(ovf_e));

    logic [4:0] mealy_vec, moore_vec, ovf_vec;
    assign mealy_vec = {m_e, m_d, m_c, m_b, m_a};
    assign moore_vec = {q_e, q_d, q_c, q_b, q_a};
    assign ovf_vec   = {ovf_e, ovf_d, ovf_c, ovf_b, ovf_a};

    always #5 clk = ~clk;

    function automatic logic [31:0] expc(input logic [31:0] v);
        return CNT_EN ? v : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input cycle: check Mealy before the edge, Moore just after it.
    task automatic step(input logic d, input logic v, input logic clr,
                        input logic [4:0] exp_hit, input string tag);
        @(negedge clk);
        din = d; din_valid = v; cnt_clr = clr;
        #1;
        chk({tag, "_mealy"}, 32'(mealy_vec), 32'(exp_hit));
        @(posedge clk);
        #1;
        chk({tag, "_moore"}, 32'(moore_vec), 32'(exp_hit));
    endtask

    // One cycle of reset with valid data driven; every output must read 0.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0; din = 1'b0; din_valid = 1'b1; cnt_clr = 1'b0;
        #1;
        chk({tag, "_rst_mealy"}, 32'(mealy_vec), 32'd0);
        chk({tag, "_rst_moore"}, 32'(moore_vec), 32'd0);
        chk({tag, "_rst_ovf"},   32'(ovf_vec),   32'd0);
        chk({tag, "_rst_cnt"},   32'(cnt_a) | 32'(cnt_b) | 32'(cnt_c) | 32'(cnt_d) | 32'(cnt_e), 32'd0);
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0;
    endtask

    initial begin
        // Phase 1: 1,1,0,1,0,1,0
        do_reset("p1");
        step(1, 1, 0, 5'b00000, "p1_b1");
        step(1, 1, 0, 5'b00000, "p1_b2");
        step(0, 1, 0, 5'b00000, "p1_b3");
        step(1, 1, 0, 5'b00000, "p1_b4");
        step(0, 1, 0, 5'b00111, "p1_b5");
        step(1, 1, 0, 5'b00000, "p1_b6");
        step(0, 1, 0, 5'b00010, "p1_b7");
        step(0, 0, 0, 5'b00000, "p1_idle");
        chk("p1_cnt_a", 32'(cnt_a), expc(1));
        chk("p1_cnt_b", 32'(cnt_b), expc(2));
        chk("p1_cnt_c", 32'(cnt_c), expc(1));

        // Phase 2: 1,0, three invalid cycles carrying 1,0,1, then 1,0
        do_reset("p2");
        step(1, 1, 0, 5'b00000, "p2_b1");
        step(0, 1, 0, 5'b00000, "p2_b2");
        step(1, 0, 0, 5'b00000, "p2_gap1");
        step(0, 0, 0, 5'b00000, "p2_gap2");
        step(1, 0, 0, 5'b00000, "p2_gap3");
        step(1, 1, 0, 5'b00000, "p2_b3");
        step(0, 1, 0, 5'b00111, "p2_b4");
        step(0, 0, 0, 5'b00000, "p2_idle");
        chk("p2_cnt_a", 32'(cnt_a), expc(1));

        // Phase 3: 1,0,1 then reset, then 0,1,0,1,0
        do_reset("p3");
        step(1, 1, 0, 5'b00000, "p3_pre1");
        step(0, 1, 0, 5'b00000, "p3_pre2");
        step(1, 1, 0, 5'b00000, "p3_pre3");
        do_reset("p3_mid");
        step(0, 1, 0, 5'b00000, "p3_b1");
        step(1, 1, 0, 5'b00000, "p3_b2");
        step(0, 1, 0, 5'b00000, "p3_b3");
        step(1, 1, 0, 5'b00000, "p3_b4");
        step(0, 1, 0, 5'b00111, "p3_b5");

        // Phase 4: repeated 1010 to saturate the 2-bit counter
        do_reset("p4");
        for (int i = 1; i <= 20; i++) begin
            logic [4:0] e;
            e = {2'b00, (i % 4 == 0), (i >= 4 && i % 2 == 0), (i % 4 == 0)};
            step(logic'(i % 2), 1, (i == 20), e, $sformatf("p4_b%0d", i));
            if (i == 12) begin
                chk("p4_cnt_c_3rd", 32'(cnt_c), expc(3));
                chk("p4_ovf_c_3rd", 32'(ovf_c), 32'd0);
            end
            if (i == 16) begin
                chk("p4_cnt_c_4th", 32'(cnt_c), expc(3));
                chk("p4_ovf_c_4th", 32'(ovf_c), expc(1));
                chk("p4_cnt_a_4th", 32'(cnt_a), expc(4));
            end
        end
        chk("p4_cnt_c_clr", 32'(cnt_c), expc(1));
        chk("p4_ovf_c_clr", 32'(ovf_c), 32'd0);
        chk("p4_cnt_a_clr", 32'(cnt_a), expc(1));

        // Phase 5: five consecutive 1s
        do_reset("p5");
        step(1, 1, 0, 5'b00000, "p5_b1");
        step(1, 1, 0, 5'b00000, "p5_b2");
        step(1, 1, 0, 5'b11000, "p5_b3");
        step(1, 1, 0, 5'b01000, "p5_b4");
        step(1, 1, 0, 5'b01000, "p5_b5");
        step(0, 0, 0, 5'b00000, "p5_idle");
        chk("p5_cnt_d", 32'(cnt_d), expc(3));
        chk("p5_cnt_e", 32'(cnt_e), expc(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
